// File: rtl/obstacle_pkg.sv
// Shared types for the obstacle line scanner: block geometry defaults,
// the per-line slot record and the scan FSM states.
package obstacle_pkg;

  localparam int OBSTACLE_WIDTH  = 10;
  localparam int OBSTACLE_HEIGHT = 20;

  // Slot field widths follow the generator's default parameterisation.
  localparam int SLOT_X_W   = 10;
  localparam int SLOT_PHY_W = 14;
  localparam int SLOT_LEN_W = 4;

  typedef struct packed {
    logic                  valid;
    logic [SLOT_X_W-1:0]   screen_x;
    logic [SLOT_LEN_W-1:0] len;
    logic [SLOT_X_W-1:0]   row;
    logic [SLOT_PHY_W-1:0] abs_x;
    logic [SLOT_PHY_W-1:0] abs_y;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_DRAIN
  } scan_state_t;

endpackage

// File: rtl/obstacle_scan_generator_if.sv
// Obstacle table read port: the scanner is the master, the table memory the
// slave. Read data is returned exactly one cycle after tbl_rd.
interface obstacle_scan_generator_if #(
  parameter int PHY_WIDTH       = 14,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int MAX_OBS         = 16
);
  localparam int ADDR_W = $clog2(MAX_OBS);

  logic                       tbl_rd;
  logic [ADDR_W-1:0]          tbl_addr;
  logic                       tbl_valid;
  logic [PHY_WIDTH-1:0]       tbl_abs_x;
  logic [PHY_WIDTH-1:0]       tbl_abs_y;
  logic [BLOCK_LEN_WIDTH-1:0] tbl_len;

  modport master (
    output tbl_rd, tbl_addr,
    input  tbl_valid, tbl_abs_x, tbl_abs_y, tbl_len
  );

  modport slave (
    input  tbl_rd, tbl_addr,
    output tbl_valid, tbl_abs_x, tbl_abs_y, tbl_len
  );
endinterface

// File: rtl/obstacle_slot_match.sv
// Horizontal range compare for one line slot: reports whether pixel_x falls
// inside the slot's run of blocks and the pixel offset from its left edge.
module obstacle_slot_match #(
  parameter int SCREEN_WIDTH    = 10,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int OBSTACLE_WIDTH  = obstacle_pkg::OBSTACLE_WIDTH
) (
  input  logic                       valid,
  input  logic [SCREEN_WIDTH-1:0]    screen_x,
  input  logic [BLOCK_LEN_WIDTH-1:0] len,
  input  logic [SCREEN_WIDTH-1:0]    pixel_x,
  output logic                       hit,
  output logic [SCREEN_WIDTH-1:0]    x_offset
);
  import obstacle_pkg::*;

  // Wide enough that screen_x + len*OBSTACLE_WIDTH never wraps.
  localparam int SPAN_W = SCREEN_WIDTH + BLOCK_LEN_WIDTH + 8;

  logic [SPAN_W-1:0] left_edge;
  logic [SPAN_W-1:0] right_edge;
  logic [SPAN_W-1:0] px;

  always_comb begin
    left_edge  = SPAN_W'(screen_x);
    px         = SPAN_W'(pixel_x);
    right_edge = left_edge + SPAN_W'(len) * SPAN_W'(OBSTACLE_WIDTH);
    hit        = valid && (px >= left_edge) && (px < right_edge);
    x_offset   = pixel_x - screen_x;
  end

endmodule

// File: rtl/obstacle_scan_generator.sv
// Per-line obstacle scanner: during hblank it walks the obstacle table, keeps
// up to LINE_SLOTS obstacles crossing the next line, then draws them during
// active video. Define OBSTACLE_SCAN_OVERFLOW_EN for a sticky scan_overflow.
module obstacle_scan_generator #(
  parameter int SCREEN_WIDTH    = 10,
  parameter int PHY_WIDTH       = 14,
  parameter int OBSTACLE_WIDTH  = obstacle_pkg::OBSTACLE_WIDTH,
  parameter int OBSTACLE_HEIGHT = obstacle_pkg::OBSTACLE_HEIGHT,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int MAX_OBS         = 16,
  parameter int LINE_SLOTS      = 4,
  parameter int V_ACTIVE        = 480
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [SCREEN_WIDTH-1:0] pixel_x,
  input  logic [SCREEN_WIDTH-1:0] pixel_y,
  input  logic                    video_on,
  input  logic                    line_start,
  input  logic [PHY_WIDTH-1:0]    camera_y,
  obstacle_scan_generator_if.master tbl,
  output logic                    obstacle_on,
  output logic [SCREEN_WIDTH-1:0] obstacle_x_rom,
  output logic [SCREEN_WIDTH-1:0] obstacle_y_rom,
  output logic [PHY_WIDTH-1:0]    obstacle_abs_pos_x,
  output logic [PHY_WIDTH-1:0]    obstacle_abs_pos_y,
  output logic [PHY_WIDTH-1:0]    obstacle_block_abs_y,
  output logic                    scan_busy,
  output logic                    scan_overflow
);
  import obstacle_pkg::*;

  localparam int ADDR_W     = $clog2(MAX_OBS);
  localparam int SLOT_IDX_W = (LINE_SLOTS > 1) ? $clog2(LINE_SLOTS) : 1;
  localparam int EXT_W      = PHY_WIDTH + 1;

  scan_state_t             state;
  logic [SCREEN_WIDTH-1:0] target_y;
  logic [SCREEN_WIDTH-1:0] next_line;
  logic                    video_on_q;
  logic                    rd_pending;
  slot_t                   slots [LINE_SLOTS];

  logic                    scan_start;
  logic                    video_rise;
  logic                    abort;
  logic                    eval_en;
  logic [EXT_W-1:0]        line_abs;
  logic [EXT_W-1:0]        entry_top;
  logic [EXT_W-1:0]        entry_bottom;
  logic                    entry_hit;
  slot_t                   new_slot;
  logic                    free_found;
  logic [SLOT_IDX_W-1:0]   free_idx;

  logic [LINE_SLOTS-1:0]   slot_hit;
  logic [SCREEN_WIDTH-1:0] slot_xoff [LINE_SLOTS];
  logic                    any_hit;
  logic [SLOT_IDX_W-1:0]   win_idx;

  // A scan only starts in blanking, so slots never change under active video
  // except for the abort clear.
  always_comb begin
    next_line    = (pixel_y == SCREEN_WIDTH'(V_ACTIVE - 1)) ? '0 : pixel_y + SCREEN_WIDTH'(1);
    scan_start   = line_start && !video_on;
    video_rise   = video_on && !video_on_q;
    abort        = !scan_start && video_rise && scan_busy;
    eval_en      = !scan_start && !abort && rd_pending;
    line_abs     = EXT_W'(camera_y) + EXT_W'(target_y);
    entry_top    = EXT_W'(tbl.tbl_abs_y);
    entry_bottom = entry_top + EXT_W'(OBSTACLE_HEIGHT);
    entry_hit    = tbl.tbl_valid && (tbl.tbl_len != '0) &&
                   (entry_top <= line_abs) && (line_abs < entry_bottom);
    new_slot          = '0;
    new_slot.valid    = 1'b1;
    new_slot.screen_x = SLOT_X_W'(tbl.tbl_abs_x[SCREEN_WIDTH-1:0]);
    new_slot.len      = SLOT_LEN_W'(tbl.tbl_len);
    new_slot.row      = SLOT_X_W'(line_abs - entry_top);
    new_slot.abs_x    = SLOT_PHY_W'(tbl.tbl_abs_x);
    new_slot.abs_y    = SLOT_PHY_W'(tbl.tbl_abs_y);
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int k = LINE_SLOTS - 1; k >= 0; k--) begin
      if (!slots[k].valid) begin
        free_found = 1'b1;
        free_idx   = SLOT_IDX_W'(k);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= ST_IDLE;
      scan_busy    <= 1'b0;
      tbl.tbl_rd   <= 1'b0;
      tbl.tbl_addr <= '0;
      rd_pending   <= 1'b0;
      target_y     <= '0;
      video_on_q   <= 1'b0;
      for (int k = 0; k < LINE_SLOTS; k++) slots[k] <= '0;
    end else begin
      video_on_q <= video_on;
      rd_pending <= tbl.tbl_rd;
      if (scan_start) begin
        state        <= ST_CLEAR;
        scan_busy    <= 1'b1;
        tbl.tbl_rd   <= 1'b0;
        tbl.tbl_addr <= '0;
        rd_pending   <= 1'b0;
        target_y     <= next_line;
      end else if (abort) begin
        state        <= ST_IDLE;
        scan_busy    <= 1'b0;
        tbl.tbl_rd   <= 1'b0;
        tbl.tbl_addr <= '0;
        rd_pending   <= 1'b0;
        for (int k = 0; k < LINE_SLOTS; k++) slots[k] <= '0;
      end else begin
        if (eval_en && entry_hit && free_found) slots[free_idx] <= new_slot;
        case (state)
          ST_CLEAR: begin
            for (int k = 0; k < LINE_SLOTS; k++) slots[k] <= '0;
            state        <= ST_FETCH;
            tbl.tbl_rd   <= 1'b1;
            tbl.tbl_addr <= '0;
          end
          ST_FETCH: begin
            if (tbl.tbl_addr == ADDR_W'(MAX_OBS - 1)) begin
              state        <= ST_DRAIN;
              tbl.tbl_rd   <= 1'b0;
              tbl.tbl_addr <= '0;
            end else begin
              tbl.tbl_addr <= tbl.tbl_addr + ADDR_W'(1);
            end
          end
          ST_DRAIN: begin
            state     <= ST_IDLE;
            scan_busy <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef OBSTACLE_SCAN_OVERFLOW_EN
  logic overflow_event;

  assign overflow_event = abort || (eval_en && entry_hit && !free_found);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) scan_overflow <= 1'b0;
    else if (overflow_event) scan_overflow <= 1'b1;
  end
`else
  assign scan_overflow = 1'b0;
`endif

  for (genvar k = 0; k < LINE_SLOTS; k++) begin : g_match
    obstacle_slot_match #(
      .SCREEN_WIDTH   (SCREEN_WIDTH),
      .BLOCK_LEN_WIDTH(BLOCK_LEN_WIDTH),
      .OBSTACLE_WIDTH (OBSTACLE_WIDTH)
    ) u_match (
      .valid   (slots[k].valid),
      .screen_x(SCREEN_WIDTH'(slots[k].screen_x)),
      .len     (BLOCK_LEN_WIDTH'(slots[k].len)),
      .pixel_x (pixel_x),
      .hit     (slot_hit[k]),
      .x_offset(slot_xoff[k])
    );
  end

  // Lowest-numbered slot wins, which is also the earliest table entry.
  always_comb begin
    any_hit = 1'b0;
    win_idx = '0;
    for (int k = LINE_SLOTS - 1; k >= 0; k--) begin
      if (slot_hit[k]) begin
        any_hit = 1'b1;
        win_idx = SLOT_IDX_W'(k);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      obstacle_on          <= 1'b0;
      obstacle_x_rom       <= '0;
      obstacle_y_rom       <= '0;
      obstacle_abs_pos_x   <= '0;
      obstacle_abs_pos_y   <= '0;
      obstacle_block_abs_y <= '0;
    end else begin
      obstacle_block_abs_y <= camera_y + PHY_WIDTH'(pixel_y);
      if (video_on && any_hit) begin
        obstacle_on        <= 1'b1;
        obstacle_x_rom     <= slot_xoff[win_idx];
        obstacle_y_rom     <= SCREEN_WIDTH'(slots[win_idx].row);
        obstacle_abs_pos_x <= PHY_WIDTH'(slots[win_idx].abs_x);
        obstacle_abs_pos_y <= PHY_WIDTH'(slots[win_idx].abs_y);
      end else begin
        obstacle_on        <= 1'b0;
        obstacle_x_rom     <= '0;
        obstacle_y_rom     <= '0;
        obstacle_abs_pos_x <= '0;
        obstacle_abs_pos_y <= '0;
      end
    end
  end

endmodule

// File: tb/tb_obstacle_scan_generator.sv
// Self-checking bench for obstacle_scan_generator: directed scenarios plus
// randomized tables compared against a line-level behavioural model.
module tb_obstacle_scan_generator;

  localparam int SW = 10, PW = 14, LW = 4, NOBS = 16, NSLOT = 4;
  localparam int OW = 10, OH = 20, VACT = 480;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] pixel_x = '0;
  logic [SW-1:0] pixel_y = '0;
  logic          video_on = 1'b0;
  logic          line_start = 1'b0;
  logic [PW-1:0] camera_y = '0;

  logic          obstacle_on;
  logic [SW-1:0] obstacle_x_rom, obstacle_y_rom;
  logic [PW-1:0] obstacle_abs_pos_x, obstacle_abs_pos_y, obstacle_block_abs_y;
  logic          scan_busy, scan_overflow;

  obstacle_scan_generator_if #(.PHY_WIDTH(PW), .BLOCK_LEN_WIDTH(LW), .MAX_OBS(NOBS)) bus ();

  obstacle_scan_generator #(
    .SCREEN_WIDTH(SW), .PHY_WIDTH(PW), .OBSTACLE_WIDTH(OW), .OBSTACLE_HEIGHT(OH),
    .BLOCK_LEN_WIDTH(LW), .MAX_OBS(NOBS), .LINE_SLOTS(NSLOT), .V_ACTIVE(VACT)
  ) dut (
    .sys_clk(clk), .sys_rst(rst),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on), .line_start(line_start),
    .camera_y(camera_y), .tbl(bus),
    .obstacle_on(obstacle_on), .obstacle_x_rom(obstacle_x_rom), .obstacle_y_rom(obstacle_y_rom),
    .obstacle_abs_pos_x(obstacle_abs_pos_x), .obstacle_abs_pos_y(obstacle_abs_pos_y),
    .obstacle_block_abs_y(obstacle_block_abs_y),
    .scan_busy(scan_busy), .scan_overflow(scan_overflow)
  );

  always #5 clk = ~clk;

  // Obstacle table contents and model state
  int m_valid [NOBS];
  int m_x     [NOBS];
  int m_y     [NOBS];
  int m_len   [NOBS];
  int cam_m  = 0;
  int line_m = 0;
  bit blank_m = 1'b1;
  bit ovf_m   = 1'b0;
  int checks = 0;
  int errors = 0;

  // Table memory: one-cycle read latency, idle bus reads as invalid
  always @(posedge clk) begin
    if (bus.tbl_rd) begin
      bus.tbl_valid <= (m_valid[bus.tbl_addr] != 0);
      bus.tbl_abs_x <= PW'(m_x[bus.tbl_addr]);
      bus.tbl_abs_y <= PW'(m_y[bus.tbl_addr]);
      bus.tbl_len   <= LW'(m_len[bus.tbl_addr]);
    end else begin
      bus.tbl_valid <= 1'b0;
      bus.tbl_abs_x <= '0;
      bus.tbl_abs_y <= '0;
      bus.tbl_len   <= '0;
    end
  end

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  function automatic bit entryHits(input int e);
    int line_abs = cam_m + line_m;
    return (m_valid[e] != 0) && (m_len[e] != 0) && (m_y[e] <= line_abs) && (line_abs < m_y[e] + OH);
  endfunction

  function automatic int hitCount();
    int n = 0;
    for (int e = 0; e < NOBS; e++) if (entryHits(e)) n++;
    return n;
  endfunction

  // First LINE_SLOTS crossing entries in table order are drawn; earliest wins.
  function automatic void modelPixel(input int px, output int on, output int xr, output int yr,
                                     output int ax, output int ay);
    int used = 0;
    on = 0; xr = 0; yr = 0; ax = 0; ay = 0;
    if (blank_m) return;
    for (int e = 0; e < NOBS; e++) begin
      if (entryHits(e) && used < NSLOT) begin
        int sx = m_x[e] % 1024;
        used++;
        if (on == 0 && px >= sx && px < sx + m_len[e] * OW) begin
          on = 1; xr = px - sx; yr = cam_m + line_m - m_y[e]; ax = m_x[e]; ay = m_y[e];
        end
      end
    end
  endfunction

  function automatic int expOvf();
`ifdef OBSTACLE_SCAN_OVERFLOW_EN
    return int'(ovf_m);
`else
    return 0;
`endif
  endfunction

  task automatic clearTable();
    for (int e = 0; e < NOBS; e++) begin
      m_valid[e] = 0; m_x[e] = 0; m_y[e] = 0; m_len[e] = 0;
    end
  endtask

  task automatic setEntry(input int e, input int x, input int y, input int len);
    m_valid[e] = 1; m_x[e] = x; m_y[e] = y; m_len[e] = len;
  endtask

  task automatic applyStimulus(input int px, input int py, input bit von);
    pixel_x  = SW'(px);
    pixel_y  = SW'(py);
    video_on = von;
    @(posedge clk); #1;
  endtask

  task automatic runScan(input int py, input string tag);
    int rd_cnt = 0, busy_cnt = 0, cyc = 0;
    bit addr_ok = 1'b1;
    video_on   = 1'b0;
    pixel_y    = SW'(py);
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    while (scan_busy && cyc < 40) begin
      busy_cnt++;
      if (bus.tbl_rd) begin
        if (int'(bus.tbl_addr) != rd_cnt) addr_ok = 1'b0;
        rd_cnt++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    line_m  = (py == VACT - 1) ? 0 : py + 1;
    cam_m   = int'(camera_y);
    blank_m = 1'b0;
    if (hitCount() > NSLOT) ovf_m = 1'b1;
    checkOutput({tag, "_rd_cycles"}, rd_cnt, NOBS);
    checkOutput({tag, "_busy_cycles"}, busy_cnt, NOBS + 2);
    checkOutput({tag, "_addr_seq"}, addr_ok, 1);
    checkOutput({tag, "_tbl_rd_idle"}, bus.tbl_rd, 0);
    checkOutput({tag, "_overflow"}, scan_overflow, expOvf());
  endtask

  task automatic checkPixel(input string tag, input int px, input bit von);
    int on, xr, yr, ax, ay;
    applyStimulus(px, line_m, von);
    modelPixel(px, on, xr, yr, ax, ay);
    if (!von) begin
      on = 0; xr = 0; yr = 0; ax = 0; ay = 0;
    end
    checkOutput({tag, "_on"}, obstacle_on, on);
    checkOutput({tag, "_x_rom"}, obstacle_x_rom, xr);
    checkOutput({tag, "_y_rom"}, obstacle_y_rom, yr);
    checkOutput({tag, "_abs_x"}, obstacle_abs_pos_x, ax);
    checkOutput({tag, "_abs_y"}, obstacle_abs_pos_y, ay);
    checkOutput({tag, "_block_abs_y"}, obstacle_block_abs_y, (int'(camera_y) + line_m) % (1 << PW));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, scan_busy, 0);
    checkOutput({tag, "_tbl_rd"}, bus.tbl_rd, 0);
    checkOutput({tag, "_tbl_addr"}, bus.tbl_addr, 0);
    checkOutput({tag, "_on"}, obstacle_on, 0);
    checkOutput({tag, "_x_rom"}, obstacle_x_rom, 0);
    checkOutput({tag, "_abs_y"}, obstacle_abs_pos_y, 0);
    checkOutput({tag, "_block_abs_y"}, obstacle_block_abs_y, 0);
    checkOutput({tag, "_overflow"}, scan_overflow, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clearTable();
    camera_y = PW'(37);
    pixel_y  = SW'(5);
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;

    // Single two-block obstacle crossing line 10
    clearTable();
    setEntry(0, 40, 95, 2);
    camera_y = PW'(100);
    runScan(9, "basic");
    checkPixel("basic_px45", 45, 1'b1);
    checkOutput("basic_px45_const_x", obstacle_x_rom, 5);
    checkOutput("basic_px45_const_y", obstacle_y_rom, 15);
    checkOutput("basic_px45_const_ay", obstacle_abs_pos_y, 95);
    checkPixel("basic_px60", 60, 1'b1);
    checkOutput("basic_px60_const_on", obstacle_on, 0);
    checkPixel("basic_px59", 59, 1'b1);
    checkOutput("basic_px59_const_x", obstacle_x_rom, 19);
    checkPixel("basic_px40", 40, 1'b1);
    checkPixel("basic_px39", 39, 1'b1);
    checkPixel("basic_novideo", 45, 1'b0);

    // Five crossing entries, only four slots
    clearTable();
    for (int e = 0; e < 5; e++) setEntry(e, 100 * e, 95, 1);
    runScan(9, "full");
    for (int e = 0; e < 5; e++) checkPixel($sformatf("full_e%0d", e), 100 * e + 3, 1'b1);
    checkOutput("full_e4_const_off", obstacle_on, 0);

    // Overlapping entries: earlier table entry wins
    clearTable();
    setEntry(2, 40, 95, 2);
    setEntry(5, 50, 95, 2);
    runScan(9, "overlap");
    checkPixel("overlap_px52", 52, 1'b1);
    checkOutput("overlap_const_ax", obstacle_abs_pos_x, 40);
    checkPixel("overlap_px65", 65, 1'b1);

    // Restart: a second line_start mid-scan retargets the line
    clearTable();
    setEntry(0, 40, 95, 2);
    setEntry(1, 200, 300, 3);
    video_on = 1'b0; pixel_y = SW'(9); line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    runScan(204, "restart");
    checkPixel("restart_px205", 205, 1'b1);
    checkOutput("restart_const_row", obstacle_y_rom, 5);
    checkPixel("restart_px45", 45, 1'b1);

    // Synchronous reset during the eighth FETCH cycle
    clearTable();
    setEntry(0, 40, 95, 2);
    video_on = 1'b0; pixel_y = SW'(9); line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("rstscan_addr7", bus.tbl_addr, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    checkResetState("rstscan");
    rst = 1'b0;
    ovf_m = 1'b0; blank_m = 1'b1; line_m = 10;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("rstscan_idle", scan_busy, 0);
    checkPixel("rstscan_px45", 45, 1'b1);

    // Wrap to line 0, then video starts during FETCH cycle 5
    clearTable();
    camera_y = PW'(200);
    setEntry(0, 10, 195, 2);
    setEntry(1, 50, 195, 2);
    setEntry(2, 90, 195, 2);
    pixel_x = SW'(15); video_on = 1'b0; pixel_y = SW'(VACT - 1); line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("abort_addr4", bus.tbl_addr, 4);
    checkOutput("abort_rd", bus.tbl_rd, 1);
    pixel_y = '0; video_on = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_busy", scan_busy, 0);
    checkOutput("abort_tbl_rd", bus.tbl_rd, 0);
    cam_m = 200; line_m = 0; blank_m = 1'b1; ovf_m = 1'b1;
    checkOutput("abort_overflow", scan_overflow, expOvf());
    checkPixel("abort_px15", 15, 1'b1);
    checkPixel("abort_px55", 55, 1'b1);
    checkPixel("abort_px95", 95, 1'b1);
    // The same line scanned without interruption is drawn (T wraps to 0)
    runScan(VACT - 1, "wrap");
    checkPixel("wrap_px55", 55, 1'b1);
    checkOutput("wrap_const_row", obstacle_y_rom, 5);

    // Randomized tables against the model
    for (int it = 0; it < 20; it++) begin
      int py = $urandom_range(0, VACT - 1);
      int t  = (py == VACT - 1) ? 0 : py + 1;
      int cam = ($urandom_range(0, 4) == 0) ? $urandom_range(16300, 16383) : $urandom_range(0, 16000);
      int dens = $urandom_range(10, 80);
      camera_y = PW'(cam);
      for (int e = 0; e < NOBS; e++) begin
        m_valid[e] = ($urandom_range(0, 99) < dens) ? 1 : 0;
        m_len[e]   = $urandom_range(0, 15);
        m_x[e]     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16383) : $urandom_range(0, 700);
        m_y[e]     = (cam + t + 3 - $urandom_range(0, 30)) & 16'h3FFF;
      end
      runScan(py, $sformatf("rnd%0d", it));
      for (int e = 0; e < NOBS; e++) begin
        if (entryHits(e)) begin
          int sx = m_x[e] % 1024;
          int ex = sx + m_len[e] * OW;
          checkPixel($sformatf("rnd%0d_e%0d_lo", it, e), sx, 1'b1);
          if (ex - 1 < 1024) checkPixel($sformatf("rnd%0d_e%0d_hi", it, e), ex - 1, 1'b1);
          if (ex < 1024) checkPixel($sformatf("rnd%0d_e%0d_out", it, e), ex, 1'b1);
        end
      end
      for (int p = 0; p < 10; p++)
        checkPixel($sformatf("rnd%0d_p%0d", it, p), $urandom_range(0, 1023), 1'b1);
      checkPixel($sformatf("rnd%0d_off", it), $urandom_range(0, 700), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obstacle_scan_generator.md
OBSTACLE_SCAN_GENERATOR -- requirements
Module: obstacle_scan_generator

Interface
REQ-001 SHALL have parameters: SCREEN_WIDTH, default 10, pixel coordinate width; PHY_WIDTH, default 14, absolute coordinate width; OBSTACLE_WIDTH, default 10, block width in pixels; OBSTACLE_HEIGHT, default 20, block height in pixels; BLOCK_LEN_WIDTH, default 4, horizontal block-count width; MAX_OBS, default 16, table depth; LINE_SLOTS, default 4, obstacles held per line; V_ACTIVE, default 480, visible lines.
REQ-002 SHALL have ports: sys_clk  in  1  clock; sys_rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: pixel_x, pixel_y  in  SCREEN_WIDTH  current scan position; video_on  in  1  active video; line_start  in  1  one-cycle pulse at hblank start after line pixel_y; camera_y  in  PHY_WIDTH  absolute y of screen row 0.
REQ-004 SHALL have table ports: tbl_rd  out  1  read strobe; tbl_addr  out  clog2(MAX_OBS)  entry index; tbl_valid  in  1  entry enabled; tbl_abs_x, tbl_abs_y  in  PHY_WIDTH  obstacle origin; tbl_len  in  BLOCK_LEN_WIDTH  blocks wide. Read data valid exactly 1 cycle after tbl_rd.
REQ-005 SHALL have outputs: obstacle_on  1; obstacle_x_rom, obstacle_y_rom  SCREEN_WIDTH  pixel offset inside obstacle; obstacle_abs_pos_x, obstacle_abs_pos_y  PHY_WIDTH  origin of hit obstacle; obstacle_block_abs_y  PHY_WIDTH  camera_y+pixel_y; scan_busy  1; scan_overflow  1.

Function
REQ-006 SHALL run FSM IDLE -> CLEAR -> FETCH -> DRAIN -> IDLE; line_start in IDLE enters CLEAR.
REQ-007 CLEAR (1 cycle) SHALL invalidate all slots and latch target line T = pixel_y+1, wrapping to 0 when pixel_y = V_ACTIVE-1.
REQ-008 FETCH SHALL issue tbl_rd with tbl_addr 0..MAX_OBS-1 on consecutive cycles; DRAIN SHALL evaluate the last return; total scan = MAX_OBS+2 cycles from line_start.
REQ-009 Entry SHALL hit when tbl_valid and tbl_len != 0 and tbl_abs_y <= camera_y+T < tbl_abs_y+OBSTACLE_HEIGHT; all sums PHY_WIDTH+1 bits, no wrap.
REQ-010 Hits SHALL fill the lowest free slot in table order, storing screen_x = tbl_abs_x[SCREEN_WIDTH-1:0], len, row = camera_y+T-tbl_abs_y, abs_x, abs_y.
REQ-011 Hit with all LINE_SLOTS full SHALL be dropped and set overflow event.
REQ-012 scan_busy SHALL be 1 in CLEAR, FETCH, DRAIN.
REQ-013 line_start while busy SHALL restart at CLEAR with new T.
REQ-014 video_on rising while busy SHALL abort to IDLE, clear all slots (blank line), raise overflow event.
REQ-015 Pixel match: slot k hits when screen_x <= pixel_x < screen_x + len*OBSTACLE_WIDTH; lowest k wins.
REQ-016 Outputs SHALL be registered, latency 1 cycle from pixel_x/video_on: obstacle_on = video_on and any hit; obstacle_x_rom = pixel_x-screen_x; obstacle_y_rom = row; abs fields from winning slot.
REQ-017 No hit or video_on=0 SHALL drive obstacle_on, x_rom, y_rom, abs_pos_x, abs_pos_y to 0; obstacle_block_abs_y always updates.
REQ-018 Slots SHALL be read-only during active video.

Reset
REQ-019 sys_rst SHALL, on sys_clk edge, force IDLE, clear slots, all outputs 0, tbl_rd 0, tbl_addr 0.
REQ-020 Reset mid-FETCH SHALL discard the scan; no slot update until next line_start.

Configuration
REQ-021 Macro OBSTACLE_SCAN_OVERFLOW_EN defined: scan_overflow SHALL be sticky on overflow event, cleared only by sys_rst.
REQ-022 Undefined: scan_overflow tied 0, overflow logic absent; slot drop/abort behaviour unchanged.

Structure
REQ-023 Package obstacle_pkg SHALL hold OBSTACLE_WIDTH, OBSTACLE_HEIGHT, slot record typedef, FSM state enum.
REQ-024 Sub-module obstacle_slot_match SHALL implement one slot's range compare and offset; instantiated LINE_SLOTS times.

Verification
REQ-025 camera_y=100, entry0 {x=40,y=95,len=2,valid}, line_start at pixel_y=9 -> tbl_rd 16 cycles, scan_busy 18 cycles; line 10 pixel_x=45 -> obstacle_on=1, x_rom=5, y_rom=15, abs_pos_y=95 next cycle.
REQ-026 Same setup, pixel_x=60 -> obstacle_on=0 (40+20 exclusive); pixel_x=59 -> x_rom=19.
REQ-027 Five valid entries overlapping line 10, LINE_SLOTS=4 -> entries 0..3 drawn, entry 4 never; scan_overflow=1 with macro, 0 without.
REQ-028 Entries 2 {x=40} and 5 {x=50} overlap, pixel_x=52 -> abs_pos_x from entry 2.
REQ-029 line_start at pixel_y=479 -> T=0; video_on raised at cycle 5 of FETCH -> IDLE, line blank, overflow set.
REQ-030 sys_rst at FETCH cycle 8 -> next cycle scan_busy=0, tbl_rd=0, all outputs 0.
